// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared divop/state encodings and decode helpers for the divider
package divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } divop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/divider_en_flop.sv
// rtl/divider_en_flop.sv - enable flop with synchronous active-high clear
module divider_en_flop #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one restoring shift-subtract iteration (combinational)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_in, dvd_bit};
  assign trial   = shifted - {2'b00, divisor};
  // A borrow out of the trial subtract means the divisor did not fit: restore.
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle signed/unsigned restoring divider (IDLE/CALC/DONE)
// Optional DIVIDER_FAST_ZERO_EN: divide-by-zero skips CALC and completes in one cycle.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       divop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result
);

  localparam int CAP_W = 2 + WIDTH + WIDTH + 3;

  state_e state, state_next;

  logic             accept, last_iter, fast_zero, work_en, res_en;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CAP_W-1:0] cap_d, cap_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_raw_q, b_mag_q;
  logic             q_neg_q, r_neg_q, b_zero_q;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] quo, quo_d, q_fin;
  logic [WIDTH:0]   rem, rem_d, step_rem;
  logic             step_q;
  logic [WIDTH-1:0] res_d, r_fin;

  assign accept = (state == S_IDLE) && valid;

`ifdef DIVIDER_FAST_ZERO_EN
  assign fast_zero = accept && (op_b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign a_neg = op_is_signed(divop) & op_a[WIDTH-1];
  assign b_neg = op_is_signed(divop) & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  assign cap_d = {divop, op_a, b_mag, a_neg ^ b_neg, a_neg, op_b == '0};
  assign {op_q, a_raw_q, b_mag_q, q_neg_q, r_neg_q, b_zero_q} = cap_q;

  divider_en_flop #(.WIDTH(CAP_W)) u_cap (
    .clk(clk), .reset(reset), .en(accept), .d(cap_d), .q(cap_q)
  );

  assign work_en   = accept || (state == S_CALC);
  assign last_iter = (state == S_CALC) && (cnt == WIDTH'(WIDTH - 1));
  assign cnt_d     = accept ? '0 : cnt + WIDTH'(1);
  assign quo_d     = accept ? a_mag : {quo[WIDTH-2:0], step_q};
  assign rem_d     = accept ? '0 : step_rem;

  divider_en_flop #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .reset(reset), .en(work_en), .d(cnt_d), .q(cnt)
  );

  divider_en_flop #(.WIDTH(WIDTH)) u_quo (
    .clk(clk), .reset(reset), .en(work_en), .d(quo_d), .q(quo)
  );

  divider_en_flop #(.WIDTH(WIDTH + 1)) u_rem (
    .clk(clk), .reset(reset), .en(work_en), .d(rem_d), .q(rem)
  );

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(rem), .dvd_bit(quo[WIDTH-1]), .divisor(b_mag_q),
    .rem_out(step_rem), .q_bit(step_q)
  );

  // Final result is taken from the last iteration's combinational output.
  assign q_fin  = {quo[WIDTH-2:0], step_q};
  assign r_fin  = step_rem[WIDTH-1:0];
  assign res_en = last_iter || fast_zero;

  always_comb begin
    res_d = '0;
    if (fast_zero) begin
      res_d = op_is_rem(divop) ? op_a : '1;
    end else if (b_zero_q) begin
      res_d = op_is_rem(op_q) ? a_raw_q : '1;
    end else if (op_is_rem(op_q)) begin
      res_d = r_neg_q ? -r_fin : r_fin;
    end else begin
      res_d = q_neg_q ? -q_fin : q_fin;
    end
  end

  divider_en_flop #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .reset(reset), .en(res_en), .d(res_d), .q(result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (valid) state_next = fast_zero ? S_DONE : S_CALC;
      S_CALC: if (last_iter) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    ready = (state == S_DONE);
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider against an arithmetic reference model
module tb_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  divop = 2'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, ready;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid), .divop(divop),
    .op_a(op_a), .op_b(op_b), .busy(busy), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint x, y;
    logic [63:0] t;
    if (b == 32'd0) return (op >= 2'd2) ? a : 32'hFFFF_FFFF;
    if (op == 2'd0 || op == 2'd2) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    t = (op >= 2'd2) ? 64'(x % y) : 64'(x / y);
    return t[31:0];
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int          exp_lat, lat;
    logic        busy_bad;
    exp = ref_model(op, a, b);
`ifdef DIVIDER_FAST_ZERO_EN
    exp_lat = (b == 32'd0) ? 1 : 33;
`else
    exp_lat = 33;
`endif
    divop = op; op_a = a; op_b = b; valid = 1'b1;
    tick;
    valid = 1'b0;
    divop = 2'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    busy_bad = 1'b0;
    while (!ready && lat < 100) begin
      if (!busy) busy_bad = 1'b1;
      tick;
      lat++;
    end
    if (!busy) busy_bad = 1'b1;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " busy"}, 32'(busy_bad), 32'd0);
    // valid presented during the DONE cycle must not start a new operation
    valid = 1'b1;
    tick;
    valid = 1'b0;
    chk({tag, " ready_pulse"}, 32'(ready), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    chk({tag, " hold"}, result, exp);
  endtask

  initial begin
    int          pulses;
    logic [31:0] got, a, b;
    logic [1:0]  op;

    reset = 1'b1;
    repeat (3) tick;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset result", result, 32'd0);
    reset = 1'b0;
    tick;

    run_op(2'd1, 32'd100, 32'd7, "divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, "remu_100_7");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_op(2'd1, 32'd5, 32'd0, "divu_5_0");
    run_op(2'd2, 32'd5, 32'd0, "rem_5_0");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd0, "div_m7_0");

    // second valid while busy is dropped, exactly one completion
    divop = 2'd1; op_a = 32'd100; op_b = 32'd7; valid = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      divop = 2'($urandom); op_a = $urandom; op_b = $urandom;
      tick;
    end
    valid = 1'b0;
    pulses = 0;
    got = '0;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        pulses++;
        got = result;
      end
      tick;
    end
    chk("busy_valid pulses", 32'(pulses), 32'd1);
    chk("busy_valid result", got, 32'd14);

    // reset mid-CALC with valid high in the reset cycle
    divop = 2'd1; op_a = 32'd1000; op_b = 32'd3; valid = 1'b1;
    tick;
    valid = 1'b0;
    repeat (8) tick;
    reset = 1'b1; valid = 1'b1;
    tick;
    reset = 1'b0; valid = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(ready), 32'd0);
    chk("abort result", result, 32'd0);
    pulses = 0;
    repeat (40) begin
      if (ready || busy) pulses++;
      tick;
    end
    chk("abort quiet", 32'(pulses), 32'd0);
    run_op(2'd1, 32'd9, 32'd3, "after_reset");

    for (int n = 0; n < 20; n++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      run_op(op, a, b, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: valid  input  1  start request, sampled only in IDLE.
REQ-005 Port: divop  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
REQ-006 Port: op_a  input  WIDTH  dividend.
REQ-007 Port: op_b  input  WIDTH  divisor.
REQ-008 Port: busy  output  1  operation accepted and not yet completed.
REQ-009 Port: ready  output  1  one-cycle completion pulse.
REQ-010 Port: result  output  WIDTH  quotient or remainder, stable from ready until the next accepted start.

Function
REQ-011 The FSM SHALL use states IDLE, CALC, DONE; IDLE->CALC on valid, CALC->DONE after exactly WIDTH iterations, DONE->IDLE unconditionally.
REQ-012 The block SHALL capture divop, op_a and op_b on the accepting edge; later input changes SHALL NOT affect the result.
REQ-013 valid accepted at edge N SHALL give ready=1 during cycle N+WIDTH+1 (33 cycles for WIDTH=32), and busy=1 from cycle N+1 through the ready cycle.
REQ-014 valid while busy SHALL be ignored and not queued.
REQ-015 Core SHALL be restoring shift-subtract: one quotient bit per CALC cycle, WIDTH-bit iteration counter, WIDTH+1-bit partial remainder.
REQ-016 DIV/REM: operands SHALL be converted to magnitudes; quotient negated iff signs differ; remainder takes dividend's sign.
REQ-017 Divisor zero: quotient SHALL be all ones, remainder SHALL be op_a, for signed and unsigned.
REQ-018 Signed overflow (op_a=-2^(WIDTH-1), op_b=-1): DIV SHALL return op_a, REM SHALL return 0.
REQ-019 result SHALL be updated only on the CALC->DONE transition.
REQ-020 valid in the DONE cycle SHALL be ignored; the next start is accepted in IDLE one cycle later.

Reset
REQ-021 reset SHALL force IDLE, busy=0, ready=0, result=0, counter=0 on the next edge, including mid-CALC and during DONE.
REQ-022 An operation aborted by reset SHALL produce no ready pulse.
REQ-023 valid asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-024 Macro DIVIDER_FAST_ZERO_EN SHALL be the only compile-time option.
REQ-025 With DIVIDER_FAST_ZERO_EN defined, an operation with op_b=0 SHALL go IDLE->DONE directly, ready one cycle after acceptance, result per REQ-017.
REQ-026 Without the macro, divide-by-zero SHALL take the full REQ-013 latency with identical result values.

Structure
REQ-027 divop encodings and state encodings SHALL live in the shared defines package, reused by the decoder and result mux.
REQ-028 One combinational sub-module div_step SHALL compute a single restoring iteration (shifted remainder, trial subtract, quotient bit); divider SHALL instantiate it once.
REQ-029 Operand capture and result registers SHALL reuse the existing enable-flop element; no new storage primitives.

Verification
REQ-030 DIVU 100/7 -> ready at cycle 33, result 14; REMU same -> 2.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; latency 1 with DIVIDER_FAST_ZERO_EN, 33 without.
REQ-034 Start DIVU 1000/3, pulse reset at cycle 10 -> busy=0, ready never pulses, result=0; new DIVU 9/3 -> 3 at full latency.
REQ-035 Second valid during CALC with different operands -> ignored; first result delivered unchanged, exactly one ready pulse.
